alu_writeback_sequencer: RTL and testbench
==========================================

# alu_writeback_sequencer

Multi-cycle issue/writeback sequencer that sits between the datapath and the 64-bit-result ALU. It accepts one operation request, registers operands and opcode onto the ALU inputs, and captures the 64-bit ALU result into an internal Z register. It then writes the result back: to the register file for 32-bit ops, or to LO and then HI for multiply/divide. It also handles nop, halt and divide-by-zero without issuing any writes.

## Interface
Parameters:
- DATA_W, 32, operand and register width; the ALU result is 2*DATA_W.
- RADDR_W, 4, register-file address width (16 GPRs).

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_opcode  in  5  operation, using the shared CPU opcode encoding.
- req_rd  in  RADDR_W  destination GPR (ignored for mul/div/nop/halt).
- req_y, req_b  in  DATA_W each  first and second operand.
- alu_y, alu_b  out  DATA_W each  registered ALU operands.
- alu_opcode  out  5  registered ALU opcode.
- alu_c  in  2*DATA_W  combinational ALU result.
- rf_we, rf_addr, rf_data  out  1/RADDR_W/DATA_W  GPR write port.
- lo_we, hi_we  out  1 each  LO/HI write strobes.
- lo_data, hi_data  out  DATA_W each  LO/HI write data.
- done  out  1  one-cycle pulse in the final cycle of each accepted op.
- div_err  out  1  one-cycle pulse: divide with req_b == 0.
- halted  out  1  sticky; set by halt, cleared only by reset.

## Operation
- States: IDLE, EXEC, WB_RF, WB_LO, WB_HI, HALT.
- IDLE: req_ready=1. On req_valid: latch alu_y/alu_b/alu_opcode/rd, go to EXEC.
- EXEC: ALU inputs stable for one full cycle. On exit, Z <= alu_c, except for nop/halt/div-by-zero, where Z is unchanged. Transitions:
  - mul (01110), div (01111) -> WB_LO.
  - nop (11001) -> IDLE, done=1 in EXEC.
  - halt (11010) -> HALT, done=1 in EXEC.
  - div with latched alu_b == 0 -> IDLE, done=1 and div_err=1 in EXEC, no writes.
  - all other opcodes -> WB_RF.
- WB_RF: rf_we=1, rf_addr=rd, rf_data=Z[31:0], done=1; then IDLE.
- WB_LO: lo_we=1, lo_data=Z[31:0]; then WB_HI.
- WB_HI: hi_we=1, hi_data=Z[63:32], done=1; then IDLE.
- HALT: halted=1, req_ready=0; absorbing until clear=0.
- Write strobes, done and div_err are Moore decodes of state; data outputs come from Z/rd registers.
- The upper half of alu_c is ignored for 32-bit ops. No sign or width manipulation happens here; the ALU defines the result.

## Timing
- Accept at edge T. EXEC spans T..T+1; Z is captured at edge T+1.
- 32-bit op: WB_RF during T+1..T+2; next accept at edge T+3 at the earliest.
- mul/div: LO write T+1..T+2, HI write T+2..T+3. LO is always written exactly one cycle before HI.
- req_valid held while busy is ignored; no queueing. A request is consumed only at an edge where req_ready=1.
- Reset (clear=0 at an edge): state=IDLE; Z, rd and alu_* cleared to 0; all strobes, done, div_err and halted are 0.
  - req_ready=1 in the cycle after reset.
  - Reset during WB_LO suppresses the pending HI write.
  - If clear=0 and req_valid=1 at the same edge, reset wins and the request is not accepted.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the 5-bit opcode constants (add 00011, sub 00100, mul 01110, div 01111, nop 11001, halt 11010, etc.);
  - the state enumeration;
  - an is_wide_op helper (mul/div).
- One sub-module, z_reg64: a 64-bit load-enable register with synchronous active-low clear, reused for the Z capture.

## Test plan
- add: req_y=5, req_b=7, rd=3 -> in cycle T+1, rf_we=1, rf_addr=3, rf_data=12, done=1; req_ready=1 at T+2.
- mul: 0x0001_0000 * 0x0001_0000 -> lo_we with lo_data=0x0000_0000 at T+1, then hi_we with hi_data=0x0000_0001 at T+2, done with hi_we; rf_we never asserted.
- div: req_y=100, req_b=0 -> div_err=1 and done=1 in EXEC; no rf/lo/hi write; then 100/7 -> lo_data/hi_data equal alu_c[31:0]/[63:32].
- halt, then req_valid held high with add -> halted=1, req_ready=0, no writes for 20 cycles; clear=0 for one edge -> halted=0, req_ready=1.
- clear=0 during WB_LO of a mul -> no hi_we, all outputs 0, req_ready=1 the next cycle.
- Back-to-back: req_valid held with two adds -> exactly two accepts, three cycles apart; nop in between -> done in EXEC with no writes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: opcodes, sequencer states
// and operation-class helpers.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB_RF,
    ST_WB_LO,
    ST_WB_HI,
    ST_HALT
  } seq_state_t;

  // Ops whose full 64-bit result lands in LO/HI
  function automatic logic is_wide_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_reg64.sv
// Load-enable result register with synchronous
// active-low clear; holds the captured ALU result.
module z_reg64 #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!clear)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/alu_writeback_sequencer.sv
// Issue/writeback sequencer: registers ALU operands,
// captures the 64-bit result and writes RF or LO/HI.
module alu_writeback_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_opcode,
  input  logic [RADDR_W-1:0]  req_rd,
  input  logic [DATA_W-1:0]   req_y,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   alu_y,
  output logic [DATA_W-1:0]   alu_b,
  output logic [4:0]          alu_opcode,
  input  logic [2*DATA_W-1:0] alu_c,
  output logic                rf_we,
  output logic [RADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic                lo_we,
  output logic                hi_we,
  output logic [DATA_W-1:0]   lo_data,
  output logic [DATA_W-1:0]   hi_data,
  output logic                done,
  output logic                div_err,
  output logic                halted
);

  seq_state_t state, state_nx;

  logic [RADDR_W-1:0]  rd_q;
  logic [2*DATA_W-1:0] z_q;
  logic                z_load;

  logic op_nop, op_halt, op_div0, op_wide;

  always_ff @(posedge clock) begin
    if (!clear)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      alu_y      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      alu_y      <= req_y;
      alu_b      <= req_b;
      alu_opcode <= req_opcode;
      rd_q       <= req_rd;
    end
  end

  // Classification of the latched op; these are mutually exclusive
  assign op_nop  = (alu_opcode == OP_NOP);
  assign op_halt = (alu_opcode == OP_HALT);
  assign op_div0 = (alu_opcode == OP_DIV) && (alu_b == '0);
  assign op_wide = is_wide_op(alu_opcode) && !op_div0;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (req_valid) state_nx = ST_EXEC;
      ST_EXEC: begin
        unique case (1'b1)
          op_div0: state_nx = ST_IDLE;
          op_nop:  state_nx = ST_IDLE;
          op_halt: state_nx = ST_HALT;
          op_wide: state_nx = ST_WB_LO;
          default: state_nx = ST_WB_RF;
        endcase
      end
      ST_WB_RF: state_nx = ST_IDLE;
      ST_WB_LO: state_nx = ST_WB_HI;
      ST_WB_HI: state_nx = ST_IDLE;
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign z_load = (state == ST_EXEC)
                && !(op_nop || op_halt || op_div0);

  z_reg64 #(
    .W (2*DATA_W)
  ) u_z (
    .clock (clock),
    .clear (clear),
    .load  (z_load),
    .d     (alu_c),
    .q     (z_q)
  );

  always_comb begin
    req_ready = 1'b0;
    rf_we     = 1'b0;
    lo_we     = 1'b0;
    hi_we     = 1'b0;
    done      = 1'b0;
    div_err   = 1'b0;
    halted    = 1'b0;
    unique case (state)
      ST_IDLE:  req_ready = 1'b1;
      ST_EXEC: begin
        done    = op_nop || op_halt || op_div0;
        div_err = op_div0;
      end
      ST_WB_RF: begin
        rf_we = 1'b1;
        done  = 1'b1;
      end
      ST_WB_LO: lo_we = 1'b1;
      ST_WB_HI: begin
        hi_we = 1'b1;
        done  = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign rf_addr = rd_q;
  assign rf_data = z_q[DATA_W-1:0];
  assign lo_data = z_q[DATA_W-1:0];
  assign hi_data = z_q[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Scoreboard bench: expected write/done events are queued at
// issue time and popped by a negedge monitor.
module tb_alu_writeback_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_opcode;
  logic [AW-1:0] req_rd;
  logic [DW-1:0] req_y, req_b;
  logic [DW-1:0] alu_y, alu_b;
  logic [4:0]    alu_opcode;
  logic [2*DW-1:0] alu_c;
  logic          rf_we, lo_we, hi_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data, lo_data, hi_data;
  logic          done, div_err, halted;

  alu_writeback_sequencer #(
    .DATA_W  (DW),
    .RADDR_W (AW)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_rd     (req_rd),
    .req_y      (req_y),
    .req_b      (req_b),
    .alu_y      (alu_y),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_c      (alu_c),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .lo_we      (lo_we),
    .hi_we      (hi_we),
    .lo_data    (lo_data),
    .hi_data    (hi_data),
    .done       (done),
    .div_err    (div_err),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  // Reference ALU: div puts quotient in LO, remainder in HI
  always_comb begin
    alu_c = 64'hA5A5_A5A5_A5A5_A5A5;
    case (alu_opcode)
      OP_ADD: alu_c = {32'h0, alu_y + alu_b};
      OP_SUB: alu_c = {32'h0, alu_y - alu_b};
      OP_MUL: alu_c = {32'h0, alu_y} * {32'h0, alu_b};
      OP_DIV:
        if (alu_b != 0)
          alu_c = {alu_y % alu_b, alu_y / alu_b};
      default: ;
    endcase
  end

  typedef struct packed {
    logic        rf;
    logic        lo;
    logic        hi;
    logic        dn;
    logic        de;
    logic [3:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_o, mon_e;
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic rf, input logic lo,
                             input logic hi, input logic dn,
                             input logic de, input logic [3:0] a,
                             input logic [31:0] d);
    ev_t e;
    e.rf = rf; e.lo = lo; e.hi = hi; e.dn = dn; e.de = de;
    e.addr = a; e.data = d;
    return e;
  endfunction

  always @(negedge clock) begin
    if (rf_we | lo_we | hi_we | done | div_err) begin
      mon_o.rf   = rf_we;
      mon_o.lo   = lo_we;
      mon_o.hi   = hi_we;
      mon_o.dn   = done;
      mon_o.de   = div_err;
      mon_o.addr = rf_we ? rf_addr : 4'h0;
      mon_o.data = rf_we ? rf_data :
                   lo_we ? lo_data :
                   hi_we ? hi_data : 32'h0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h t=%0t",
                 mon_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          errors++;
          $display("FAIL event got=%h want=%h t=%0t",
                   mon_o, mon_e, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, got, want, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("ready_timeout", {63'h0, req_ready}, 64'h1);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] rd,
                       input logic [31:0] y, input logic [31:0] b);
    wait_ready();
    req_valid  = 1'b1;
    req_opcode = op;
    req_rd     = rd;
    req_y      = y;
    req_b      = b;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int first_at;
    int second_at;
    clear      = 1'b0;
    req_valid  = 1'b1;
    req_opcode = OP_ADD;
    req_rd     = 4'd2;
    req_y      = 32'd9;
    req_b      = 32'd9;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("reset_ready", {63'h0, req_ready}, 64'h1);
    chk("reset_alu", {alu_y, alu_b[26:0], alu_opcode}, 64'h0);
    chk("reset_flags",
        {58'h0, halted, rf_we, lo_we, hi_we, done, div_err}, 64'h0);

    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd3, 32'd12));
    issue(OP_ADD, 4'd3, 32'd5, 32'd7);
    @(negedge clock);
    chk("add_exec_ready", {63'h0, req_ready}, 64'h0);
    chk("add_alu_y", {32'h0, alu_y}, 64'd5);
    @(negedge clock);
    chk("add_wb_ready", {63'h0, req_ready}, 64'h0);
    @(negedge clock);
    chk("add_idle_ready", {63'h0, req_ready}, 64'h1);

    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd15, 32'd11));
    issue(OP_SUB, 4'd15, 32'd20, 32'd9);
    repeat (3) @(negedge clock);

    exp_q.push_back(mk(0, 1, 0, 0, 0, 4'd0, 32'h0000_0000));
    exp_q.push_back(mk(0, 0, 1, 1, 0, 4'd0, 32'h0000_0001));
    issue(OP_MUL, 4'd9, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(negedge clock);

    exp_q.push_back(mk(0, 0, 0, 1, 1, 4'd0, 32'h0));
    issue(OP_DIV, 4'd6, 32'd100, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("div0_ready", {63'h0, req_ready}, 64'h1);

    exp_q.push_back(mk(0, 1, 0, 0, 0, 4'd0, 32'd14));
    exp_q.push_back(mk(0, 0, 1, 1, 0, 4'd0, 32'd2));
    issue(OP_DIV, 4'd6, 32'd100, 32'd7);
    repeat (4) @(negedge clock);

    wait_ready();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd1, 32'd3));
    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd1, 32'd3));
    req_valid  = 1'b1;
    req_opcode = OP_ADD;
    req_rd     = 4'd1;
    req_y      = 32'd1;
    req_b      = 32'd2;
    accepts    = 0;
    first_at   = -1;
    second_at  = -1;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) begin
        if (accepts == 0) first_at = i;
        else second_at = i;
        accepts++;
      end
      @(posedge clock);
      #1;
      if (i == 5) req_valid = 1'b0;
      @(negedge clock);
    end
    chk("b2b_accepts", 64'(accepts), 64'd2);
    chk("b2b_spacing", 64'(second_at - first_at), 64'd3);

    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd4, 32'd30));
    issue(OP_ADD, 4'd4, 32'd10, 32'd20);
    exp_q.push_back(mk(0, 0, 0, 1, 0, 4'd0, 32'h0));
    issue(OP_NOP, 4'd8, 32'd77, 32'd88);
    @(negedge clock);
    @(negedge clock);
    chk("nop_ready", {63'h0, req_ready}, 64'h1);
    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd5, 32'd8));
    issue(OP_ADD, 4'd5, 32'd3, 32'd5);
    repeat (3) @(negedge clock);

    exp_q.push_back(mk(0, 1, 0, 0, 0, 4'd0, 32'd12));
    issue(OP_MUL, 4'd0, 32'd3, 32'd4);
    @(negedge clock);
    @(negedge clock);
    #1 clear = 1'b0;
    @(posedge clock);
    #1 clear = 1'b1;
    @(negedge clock);
    chk("rst_lo_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_lo_flags",
        {58'h0, halted, rf_we, lo_we, hi_we, done, div_err}, 64'h0);
    chk("rst_lo_data", {lo_data, hi_data}, 64'h0);
    chk("rst_lo_alu", {alu_y, alu_b[26:0], alu_opcode}, 64'h0);
    chk("rst_lo_rf", {28'h0, rf_addr, rf_data}, 64'h0);
    repeat (2) @(negedge clock);

    exp_q.push_back(mk(0, 0, 0, 1, 0, 4'd0, 32'h0));
    issue(OP_HALT, 4'd0, 32'd0, 32'd0);
    @(negedge clock);
    req_valid  = 1'b1;
    req_opcode = OP_ADD;
    req_rd     = 4'd2;
    req_y      = 32'd1;
    req_b      = 32'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("halt_hold", {62'h0, halted, req_ready}, 64'h2);
    end
    #1 clear = 1'b0;
    @(posedge clock);
    #1 clear = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("halt_cleared", {62'h0, halted, req_ready}, 64'h1);

    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'd7, 32'd123));
    issue(OP_ADD, 4'd7, 32'd100, 32'd23);
    repeat (4) @(negedge clock);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
